// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load size encodings, grant codes
// and architectural widths.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load alignment: shifts the accessed bytes down, keeps the access
// width, sign/zero-extends it, and flags offsets not aligned to the access size.
module load_extender
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0]      sz,
                                             input logic            uns);
    logic ext;
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B: begin
        ext = !uns && v[7];
        r   = {{56{ext}}, v[7:0]};
      end
      SZ_H: begin
        ext = !uns && v[15];
        r   = {{48{ext}}, v[15:0]};
      end
      SZ_W: begin
        ext = !uns && v[31];
        r   = {{32{ext}}, v[31:0]};
      end
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
    logic m;
    case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

  assign shifted    = data >> {offset, 3'b000};
  assign value      = extend(shifted, size, is_unsigned);
  assign misaligned = is_misaligned(offset, size);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and load results into a single registered
// register-file write per cycle, with starvation protection for the ALU.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [2:0]            ld_offset,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [XLEN-1:0]       write_value,
  input  logic                  write_ready,
  output logic                  misalign_err,
  output logic                  wb_idle
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             out_valid;
  logic [CNT_W-1:0] starve_cnt;
  logic             can_load;
  grant_t           grant;
  logic [XLEN-1:0]  ld_value;
  logic             ld_misaligned;

  load_extender u_ext (
    .data        (ld_data),
    .offset      (ld_offset),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .value       (ld_value),
    .misaligned  (ld_misaligned)
  );

  assign can_load = !out_valid || write_ready;

  // Loads win contention until the ALU has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant = GNT_NONE;
    if (can_load) begin
      if (alu_valid && ld_valid)
        grant = (starve_cnt == LIMIT) ? GNT_ALU : GNT_LD;
      else if (alu_valid)
        grant = GNT_ALU;
      else if (ld_valid)
        grant = GNT_LD;
    end
  end

  assign alu_ready    = (grant == GNT_ALU);
  assign ld_ready     = (grant == GNT_LD);
  assign write_enable = out_valid && (write_register != '0);
  assign wb_idle      = !out_valid && !alu_valid && !ld_valid;

  // Starvation counter saturates at the limit so a long stall cannot wrap past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (alu_valid && grant != GNT_ALU) begin
      if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Output register stage: one pending write, held until write_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      write_register <= '0;
      write_value    <= '0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= (grant == GNT_LD) && ld_misaligned;
      if (can_load) begin
        case (grant)
          GNT_ALU: begin
            out_valid      <= 1'b1;
            write_register <= alu_rd;
            write_value    <= alu_result;
          end
          GNT_LD: begin
            // A misaligned load is consumed but produces no write.
            out_valid <= !ld_misaligned;
            if (!ld_misaligned) begin
              write_register <= ld_rd;
              write_value    <= ld_value;
            end
          end
          default: out_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a vector table of single transactions plus
// sequences for contention, backpressure, x0 writes and asynchronous reset.
module tb_writeback_unit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_result;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_offset;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        write_enable;
  logic [4:0]  write_register;
  logic [63:0] write_value;
  logic        write_ready;
  logic        misalign_err;
  logic        wb_idle;

  always #5 clk = ~clk;

  writeback_unit #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_result     (alu_result),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_offset      (ld_offset),
    .ld_size        (ld_size),
    .ld_unsigned    (ld_unsigned),
    .write_enable   (write_enable),
    .write_register (write_register),
    .write_value    (write_value),
    .write_ready    (write_ready),
    .misalign_err   (misalign_err),
    .wb_idle        (wb_idle)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ares;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ldat;
    logic [2:0]  loff;
    logic [1:0]  lsz;
    logic        luns;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [63:0] e_val;
    logic        e_merr;
  } vec_t;

  vec_t vecs[14];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ld_offset = '0; ld_size = '0; ld_unsigned = 1'b0;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd5,  64'h80FF, 3'd1, SZ_B, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd5,  64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd5,  64'h80FF, 3'd1, SZ_B, 1'b1,
                 1'b0, 1'b1, 1'b1, 5'd5,  64'h80, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd7,  64'h1234_5678_9ABC_DEF0, 3'd2, SZ_H, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd7,  64'hFFFF_FFFF_FFFF_9ABC, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd7,  64'h1234_5678_9ABC_DEF0, 3'd2, SZ_H, 1'b1,
                 1'b0, 1'b1, 1'b1, 5'd7,  64'h9ABC, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd8,  64'h1234_5678_9ABC_DEF0, 3'd4, SZ_W, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd8,  64'h1234_5678, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd9,  64'h8000_0001, 3'd0, SZ_W, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd9,  64'hFFFF_FFFF_8000_0001, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd9,  64'h8000_0001, 3'd0, SZ_W, 1'b1,
                 1'b0, 1'b1, 1'b1, 5'd9,  64'h8000_0001, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hF000_0000_0000_0001, 3'd0, SZ_D, 1'b1,
                 1'b0, 1'b1, 1'b1, 5'd31, 64'hF000_0000_0000_0001, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd1,  64'hFE00_0000_0000_0000, 3'd7, SZ_B, 1'b0,
                 1'b0, 1'b1, 1'b1, 5'd1,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[9]  = '{1'b1, 5'd3, 64'd42, 1'b0, 5'd0, 64'd0, 3'd0, SZ_B, 1'b0,
                 1'b1, 1'b0, 1'b1, 5'd3,  64'd42, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd4,  64'h1111_2222_3333_4444, 3'd2, SZ_W, 1'b0,
                 1'b0, 1'b1, 1'b0, 5'd0,  64'd0, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd4,  64'h1111_2222_3333_4444, 3'd3, SZ_H, 1'b0,
                 1'b0, 1'b1, 1'b0, 5'd0,  64'd0, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd4,  64'h1111_2222_3333_4444, 3'd4, SZ_D, 1'b0,
                 1'b0, 1'b1, 1'b0, 5'd0,  64'd0, 1'b1};
    vecs[13] = '{1'b1, 5'd2, 64'h55, 1'b1, 5'd6, 64'h12, 3'd0, SZ_B, 1'b1,
                 1'b0, 1'b1, 1'b1, 5'd6,  64'h12, 1'b0};

    // Reset state
    reset = 1'b1;
    write_ready = 1'b1;
    idle_inputs();
    #12;
    chk("reset_we",   {63'd0, write_enable}, 64'd0);
    chk("reset_reg",  {59'd0, write_register}, 64'd0);
    chk("reset_val",  write_value, 64'd0);
    chk("reset_merr", {63'd0, misalign_err}, 64'd0);
    chk("reset_idle", {63'd0, wb_idle}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    after_pos();

    // Table: one transaction from idle, then one idle cycle to retire it
    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_result = vecs[i].ares;
      ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_data = vecs[i].ldat;
      ld_offset = vecs[i].loff; ld_size = vecs[i].lsz; ld_unsigned = vecs[i].luns;
      write_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_alu_ready", i), {63'd0, alu_ready}, {63'd0, vecs[i].e_ar});
      chk($sformatf("v%0d_ld_ready", i),  {63'd0, ld_ready},  {63'd0, vecs[i].e_lr});
      after_pos();
      chk($sformatf("v%0d_we", i),   {63'd0, write_enable}, {63'd0, vecs[i].e_we});
      chk($sformatf("v%0d_merr", i), {63'd0, misalign_err}, {63'd0, vecs[i].e_merr});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_reg", i), {59'd0, write_register}, {59'd0, vecs[i].e_reg});
        chk($sformatf("v%0d_val", i), write_value, vecs[i].e_val);
      end
      idle_inputs();
      after_pos();
      chk($sformatf("v%0d_retired_we", i), {63'd0, write_enable}, 64'd0);
      chk($sformatf("v%0d_merr_clear", i), {63'd0, misalign_err}, 64'd0);
      chk($sformatf("v%0d_idle", i), {63'd0, wb_idle}, 64'd1);
    end

    // Contention: ALU forced through on the fifth cycle
    alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 64'hA000;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_size = SZ_D; ld_offset = 3'd0;
    for (int c = 0; c < 8; c++) begin
      ld_data = 64'(c + 1);
      @(negedge clk);
      chk($sformatf("fair%0d_alu_ready", c), {63'd0, alu_ready}, (c == 4) ? 64'd1 : 64'd0);
      chk($sformatf("fair%0d_ld_ready", c),  {63'd0, ld_ready},  (c == 4) ? 64'd0 : 64'd1);
      after_pos();
      chk($sformatf("fair%0d_reg", c), {59'd0, write_register}, (c == 4) ? 64'd2 : 64'd9);
      chk($sformatf("fair%0d_val", c), write_value, (c == 4) ? 64'hA000 : 64'(c + 1));
    end
    idle_inputs();
    after_pos();

    // Backpressure: pending ALU write held while write_ready is low
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 64'd42;
    after_pos();
    chk("bp_accept_we", {63'd0, write_enable}, 64'd1);
    idle_inputs();
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 64'hBEEF; ld_size = SZ_D;
    write_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_alu_ready", c), {63'd0, alu_ready}, 64'd0);
      chk($sformatf("bp%0d_ld_ready", c),  {63'd0, ld_ready},  64'd0);
      chk($sformatf("bp%0d_we", c),  {63'd0, write_enable}, 64'd1);
      chk($sformatf("bp%0d_reg", c), {59'd0, write_register}, 64'd3);
      chk($sformatf("bp%0d_val", c), write_value, 64'd42);
      after_pos();
    end
    write_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ld_ready", {63'd0, ld_ready}, 64'd1);
    after_pos();
    chk("bp_new_reg", {59'd0, write_register}, 64'd10);
    chk("bp_new_val", write_value, 64'hBEEF);
    idle_inputs();
    after_pos();

    // x0 destination occupies the slot without a write strobe
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 64'd7;
    @(negedge clk);
    chk("x0_alu_ready", {63'd0, alu_ready}, 64'd1);
    after_pos();
    chk("x0_we",   {63'd0, write_enable}, 64'd0);
    chk("x0_busy", {63'd0, wb_idle}, 64'd0);
    idle_inputs();
    after_pos();
    chk("x0_idle", {63'd0, wb_idle}, 64'd1);

    // Asynchronous reset during a stall with a starving ALU
    alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 64'd99;
    after_pos();
    chk("ar_accept_we", {63'd0, write_enable}, 64'd1);
    write_ready = 1'b0;
    alu_rd = 5'd11;
    for (int c = 0; c < 5; c++) after_pos();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_we_drop", {63'd0, write_enable}, 64'd0);
    chk("ar_val",     write_value, 64'd0);
    chk("ar_reg",     {59'd0, write_register}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("ar_idle", {63'd0, wb_idle}, 64'd1);
    write_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_result = 64'h77;
    ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 64'h88; ld_size = SZ_D;
    #1;
    chk("ar_cnt_ld_ready",  {63'd0, ld_ready},  64'd1);
    chk("ar_cnt_alu_ready", {63'd0, alu_ready}, 64'd0);
    after_pos();
    chk("ar_post_reg", {59'd0, write_register}, 64'd13);
    idle_inputs();
    after_pos();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
